// File: rtl/ups_pkg.sv
// ups_pkg: shared types and default constants for the UPS converter
// interfaces (ADC read path and DAC write path).
//   ad_state_t      - ADC read sequencer states
//   UPS_AD_*        - default timing/width parameters
//   ad_spi_active() - true while the SPI frame (CS_N low) is in progress
package ups_pkg;

  typedef enum logic [2:0] {
    AD_INIT     = 3'd0,
    AD_CONV     = 3'd1,
    AD_CS_START = 3'd2,
    AD_RCV      = 3'd3,
    AD_DONE     = 3'd4
  } ad_state_t;

  localparam int unsigned UPS_AD_CLK_DIV     = 4;
  localparam int unsigned UPS_AD_CONV_CYCLES = 100;
  localparam int unsigned UPS_AD_DATA_W      = 16;

  // States in which the ADC is selected and SCLK is driven.
  function automatic logic ad_spi_active(input ad_state_t s);
    logic act;
    case (s)
      AD_CS_START, AD_RCV, AD_DONE: act = 1'b1;
      default:                      act = 1'b0;
    endcase
    return act;
  endfunction

endpackage

// File: rtl/ups_sclk_gen.sv
// ups_sclk_gen: enable-gated SPI clock divider.
//   clk_i   - system clock
//   rst_ni  - asynchronous active-low reset
//   en_i    - run the divider; when low, sclk returns to 1 and the divider clears
//   sclk_o  - registered SPI clock, idles high, half-period CLK_DIV clk cycles
//   rise_o  - high in the cycle whose closing edge drives sclk 0->1
//   fall_o  - high in the cycle whose closing edge drives sclk 1->0
// The strobes do not depend on en_i, so a client may drop en_i in reaction to
// a strobe: sclk then stays high instead of toggling.
module ups_sclk_gen
  import ups_pkg::*;
#(
  parameter int unsigned CLK_DIV = UPS_AD_CLK_DIV
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic             sclk_q, sclk_d;
  logic             tick_s;

  // The divider is held at 0 while disabled and CLK_DIV >= 2, so no tick then.
  assign tick_s = (div_q == DIV_W'(CLK_DIV - 1));
  assign rise_o = tick_s & ~sclk_q;
  assign fall_o = tick_s & sclk_q;
  assign sclk_o = sclk_q;

  always_comb begin
    div_d  = div_q;
    sclk_d = sclk_q;
    if (!en_i) begin
      div_d  = '0;
      sclk_d = 1'b1;
    end else if (tick_s) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= '0;
      sclk_q <= 1'b1;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/ups_ad.sv
// ups_ad: read interface for a 16-bit SAR ADC with CNV/SPI read-back.
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   start_i  - request one conversion (sampled only when idle)
//   busy_o   - high while a conversion/read is in progress
//   dv_o     - one-cycle data-valid strobe
//   data_o   - last converted word, held until the next dv_o
//   sclk_o   - SPI clock to the ADC, idles high
//   din_i    - ADC SDO
//   cnv_o    - conversion start, active high
//   cs_n_o   - ADC chip select, active low
// Sequence: CNV high CONV_CYCLES, CS_N low with SCLK high CLK_DIV cycles,
// 16 full SCLK periods capturing on each rise, CLK_DIV cycles of hold, then dv.
module ups_ad
  import ups_pkg::*;
#(
  parameter int unsigned CLK_DIV     = UPS_AD_CLK_DIV,
  parameter int unsigned CONV_CYCLES = UPS_AD_CONV_CYCLES,
  parameter int unsigned DATA_W      = UPS_AD_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  output logic              busy_o,
  output logic              dv_o,
  output logic [DATA_W-1:0] data_o,
  output logic              sclk_o,
  input  logic              din_i,
  output logic              cnv_o,
  output logic              cs_n_o
);

  localparam int unsigned CNT_W = $clog2(CONV_CYCLES);
  localparam int unsigned BIT_W = $clog2(DATA_W + 1);

  ad_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              din_q;
  logic              cnv_q, cs_n_q, busy_q, dv_q;
  logic              cnv_d, cs_n_d, busy_d, dv_d;
  logic              term_s, en_s, rise_s, fall_s;

  // term_s marks the fall strobes that end RCV and DONE; dropping the enable
  // there keeps sclk high and restarts the divider for the next phase.
  assign en_s = ad_spi_active(state_q) & ~term_s;

  ups_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (en_s),
    .sclk_o(sclk_o),
    .rise_o(rise_s),
    .fall_o(fall_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    term_s  = 1'b0;
    case (state_q)
      AD_INIT: begin
        if (start_i) begin
          state_d = AD_CONV;
          cnt_d   = CNT_W'(CONV_CYCLES - 1);
        end else begin
          state_d = AD_INIT;
        end
      end
      AD_CONV: begin
        if (cnt_q == '0) begin
          state_d = AD_CS_START;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      AD_CS_START: begin
        if (fall_s) begin
          state_d = AD_RCV;
          bit_d   = BIT_W'(DATA_W);
        end else begin
          state_d = AD_CS_START;
        end
      end
      AD_RCV: begin
        if (rise_s) begin
          shift_d = {shift_q[DATA_W-2:0], din_q};
          bit_d   = bit_q - BIT_W'(1);
        end else if (fall_s && (bit_q == '0)) begin
          state_d = AD_DONE;
          term_s  = 1'b1;
        end else begin
          state_d = AD_RCV;
        end
      end
      AD_DONE: begin
        if (fall_s) begin
          state_d = AD_INIT;
          term_s  = 1'b1;
        end else begin
          state_d = AD_DONE;
        end
      end
      default: begin
        state_d = AD_INIT;
      end
    endcase
  end

  // Outputs are derived from the next state so they change on the same edge
  // as the state register.
  always_comb begin
    cnv_d  = (state_d == AD_CONV);
    cs_n_d = ~ad_spi_active(state_d);
    busy_d = (state_d != AD_INIT);
    dv_d   = (state_q == AD_DONE) && (state_d == AD_INIT);
    if (dv_d) begin
      data_d = shift_q;
    end else begin
      data_d = data_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= AD_INIT;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      din_q   <= 1'b0;
      cnv_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      din_q   <= din_i;
      cnv_q   <= cnv_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      dv_q    <= dv_d;
    end
  end

  assign busy_o = busy_q;
  assign dv_o   = dv_q;
  assign data_o = data_q;
  assign cnv_o  = cnv_q;
  assign cs_n_o = cs_n_q;

endmodule
